// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 constants and special-value helpers shared with fp16add
package fp16_pkg;

  localparam int         EXP_BIAS  = 15;
  localparam logic [4:0] EXP_MAX   = 5'h1F;
  localparam logic [9:0] QNAN_FRAC = 10'h200;

  typedef enum logic [1:0] {
    KIND_NORM,
    KIND_ZERO,
    KIND_INF,
    KIND_NAN
  } kind_t;

  // Encodes a non-normal result; sign is always carried through.
  function automatic logic [15:0] pack_special(input logic s, input kind_t k);
    case (k)
      KIND_NAN: return {s, EXP_MAX, QNAN_FRAC};
      KIND_INF: return {s, EXP_MAX, 10'h000};
      default:  return {s, 15'h0000};
    endcase
  endfunction

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - FP16 operand classifier (flush-to-zero) with hidden-bit mantissa
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [4:0]  exp_f,
  input  logic [9:0]  frac,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic [10:0] mant
);

  // Denormals (exp==0) are treated as zero.
  assign is_zero = (exp_f == 5'd0);
  assign is_inf  = (exp_f == EXP_MAX) && (frac == 10'd0);
  assign is_nan  = (exp_f == EXP_MAX) && (frac != 10'd0);
  assign mant    = {1'b1, frac};

endmodule

// File: rtl/fp16_mul_pipe.sv
// rtl/fp16_mul_pipe.sv - three-stage FP16 multiplier, truncating, FTZ, single global stall
module fp16_mul_pipe
  import fp16_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [TAG_W-1:0] out_tag
);

  logic en;
  logic v1, v2, v3;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [10:0] a_mant, b_mant;

  fp16_classify u_cls_a (
    .exp_f   (in_a[14:10]),
    .frac    (in_a[9:0]),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .mant    (a_mant)
  );

  fp16_classify u_cls_b (
    .exp_f   (in_b[14:10]),
    .frac    (in_b[9:0]),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .mant    (b_mant)
  );

  kind_t              kind_in;
  logic signed [6:0]  esum;

  assign esum = $signed({2'b00, in_a[14:10]}) + $signed({2'b00, in_b[14:10]}) - 7'(EXP_BIAS);

  always_comb begin
    kind_in = KIND_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) kind_in = KIND_NAN;
    else if (a_inf || b_inf)                                      kind_in = KIND_INF;
    else if (a_zero || b_zero)                                    kind_in = KIND_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  logic               s1_sign, s2_sign;
  logic signed [6:0]  s1_exp, s2_exp;
  kind_t              s1_kind, s2_kind;
  logic [10:0]        s1_ma, s1_mb;
  logic [11:0]        s2_prod;
  logic [TAG_W-1:0]   s1_tag, s2_tag;

  // Only product bits [21:10] matter under truncation, so S2 keeps just those.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= in_a[15] ^ in_b[15];
      s1_exp  <= esum;
      s1_kind <= kind_in;
      s1_ma   <= a_mant;
      s1_mb   <= b_mant;
      s1_tag  <= in_tag;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_kind <= s1_kind;
      s2_prod <= 12'(({11'b0, s1_ma} * {11'b0, s1_mb}) >> 10);
      s2_tag  <= s1_tag;
    end
  end

  logic signed [6:0] exp_n;
  logic [9:0]        frac_n;
  logic [15:0]       result;

  always_comb begin
    exp_n  = s2_exp + (s2_prod[11] ? 7'sd1 : 7'sd0);
    frac_n = s2_prod[11] ? s2_prod[10:1] : s2_prod[9:0];
    result = {s2_sign, exp_n[4:0], frac_n};
    if (s2_kind != KIND_NORM)   result = pack_special(s2_sign, s2_kind);
    else if (exp_n >= 7'sd31)   result = pack_special(s2_sign, KIND_INF);
    else if (exp_n <= 7'sd0)    result = pack_special(s2_sign, KIND_ZERO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p   <= 16'h0000;
      out_tag <= '0;
    end else if (en) begin
      out_p   <= result;
      out_tag <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fp16_mul_pipe.sv
// tb/tb_fp16_mul_pipe.sv - vector table, backpressure, random streaming and reset checks for fp16_mul_pipe
module tb_fp16_mul_pipe;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_p;
  logic [TW-1:0] out_tag;

  fp16_mul_pipe #(.TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   p;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } vec_t;

  exp_t        exp_q[$];
  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  bit          use_tab = 0;
  bit          lat_chk = 0;
  bit          rnd_rdy = 0;
  logic [15:0] tab_exp = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Value-level reference: decode to reals, multiply exactly, re-encode truncating with FTZ.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   ea, eb, fa, fb, e, be, fr;
    bit   za, zb, ia, ib, na, nb;
    real  x;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); fa = int'(a[9:0]);
    eb = int'(b[14:10]); fb = int'(b[9:0]);
    za = (ea == 0); ia = (ea == 31 && fa == 0); na = (ea == 31 && fa != 0);
    zb = (eb == 0); ib = (eb == 31 && fb == 0); nb = (eb == 31 && fb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {s, 5'h1F, 10'h200};
    if (ia || ib) return {s, 5'h1F, 10'h000};
    if (za || zb) return {s, 15'h0000};
    x = (1.0 + fa / 1024.0) * pow2(ea - 15) * (1.0 + fb / 1024.0) * pow2(eb - 15);
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    be = e + 15;
    if (be >= 31) return {s, 5'h1F, 10'h000};
    if (be <= 0)  return {s, 15'h0000};
    fr = $rtoi((x - 1.0) * 1024.0);
    return {s, be[4:0], fr[9:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Transfers are sampled on the falling edge; they complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e.p   = use_tab ? tab_exp : ref_mul(in_a, in_b);
        e.tag = in_tag;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_p), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("product", 32'(out_p), 32'(e.p));
          chk("tag_order", 32'(out_tag), 32'(e.tag));
          if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [TW-1:0] t);
    bit acc = 0;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    for (int c = 0; c < 500 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    int          k, seen, cnt0;
    bit          acc;
    logic [15:0] p0, ra, rb;

    vecs[0] = '{16'h3C00, 16'h3C00, 16'h3C00};
    vecs[1] = '{16'h4000, 16'hC200, 16'hC600};
    vecs[2] = '{16'h3E00, 16'h3E00, 16'h4080};
    vecs[3] = '{16'h7C00, 16'h0000, 16'h7E00};
    vecs[4] = '{16'h7E01, 16'h3C00, 16'h7E00};
    vecs[5] = '{16'hFC00, 16'h4000, 16'hFC00};
    vecs[6] = '{16'h8000, 16'h3C00, 16'h8000};
    vecs[7] = '{16'h7BFF, 16'h7BFF, 16'h7C00};
    vecs[8] = '{16'h0400, 16'h0400, 16'h0000};
    vecs[9] = '{16'h0001, 16'h3C00, 16'h0000};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_tag = '0; out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_p", 32'(out_p), 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    use_tab = 1; lat_chk = 1;
    for (int i = 0; i < 10; i++) begin
      tab_exp = vecs[i].p;
      send(vecs[i].a, vecs[i].b, TW'(i));
    end
    in_valid = 1'b0;
    drain();
    use_tab = 0; lat_chk = 0;

    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      in_a = 16'h4000 + 16'(k) * 16'h0100; in_b = 16'h3E00; in_tag = TW'(k); in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    chk("bp_accepted", 32'(k), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_value", 32'(out_p), 32'(ref_mul(16'h4000, 16'h3E00)));
    p0 = out_p;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable_p", 32'(out_p), 32'(p0));
      chk("bp_stable_tag", 32'(out_tag), 32'd0);
    end
    @(posedge clk);
    #1;
    cnt0 = out_cnt;
    out_ready = 1'b1;
    while (k < 5) begin
      send(16'h4000 + 16'(k) * 16'h0100, 16'h3E00, TW'(k));
      k++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_out_count", 32'(out_cnt - cnt0), 32'd5);

    rnd_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      send(ra, rb, TW'(i));
    end
    in_valid = 1'b0;
    drain();
    rnd_rdy = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;

    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h3C00, 16'h3C00, 8'hA0);
    send(16'h4000, 16'h4000, 8'hA1);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_stale", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send(16'h3E00, 16'h3E00, 8'h55);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
